riscvbc_mem_arb: RTL and testbench

RISCVBC_MEM_ARB -- requirements
Module: riscvbc_mem_arb

---
 rtl/riscvbc_mem_arb_pkg.sv | 36 +++
 rtl/riscvbc_tag_fifo.sv | 54 +++++
 rtl/riscvbc_mem_arb.sv | 100 ++++++++++
 tb/tb_riscvbc_mem_arb.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscvbc_mem_arb_pkg.sv
// Shared constants for the two-cache memory arbiter.
// Message sizes and field layouts of the vc mem-msg format, the 1-bit port-ID
// type and the default tag-queue depth.
package riscvbc_mem_arb_pkg;

    // vc mem request: {type, addr, len, data}; len encodes bytes, 0 = full word
    function automatic int unsigned vc_mem_req_msg_sz(input int unsigned addr_w,
                                                      input int unsigned data_w);
        return 1 + addr_w + $clog2(data_w / 8) + data_w;
    endfunction

    // vc mem response: {type, len, data}
    function automatic int unsigned vc_mem_resp_msg_sz(input int unsigned data_w);
        return 1 + $clog2(data_w / 8) + data_w;
    endfunction

    localparam int unsigned VcMemAddrW     = 32;
    localparam int unsigned VcMemDataW     = 32;
    localparam int unsigned VcMemReqMsgSz  = vc_mem_req_msg_sz(VcMemAddrW, VcMemDataW);
    localparam int unsigned VcMemRespMsgSz = vc_mem_resp_msg_sz(VcMemDataW);

    // Request field layout (MSB first)
    localparam int unsigned VcMemReqTypeBit = VcMemReqMsgSz - 1;
    localparam int unsigned VcMemReqAddrMsb = VcMemReqMsgSz - 2;
    localparam int unsigned VcMemReqAddrLsb = VcMemReqMsgSz - 1 - VcMemAddrW;
    localparam int unsigned VcMemReqDataMsb = VcMemDataW - 1;

    // Response field layout (MSB first)
    localparam int unsigned VcMemRespTypeBit = VcMemRespMsgSz - 1;
    localparam int unsigned VcMemRespDataMsb = VcMemDataW - 1;

    // riscvbc constants
    typedef logic port_id_t;
    localparam int unsigned RiscvbcMemArbDepth = 4;

endpackage

// File: rtl/riscvbc_tag_fifo.sv
// In-order queue of port IDs for outstanding memory requests.
// Ports: clk, reset (sync, active-high); push/push_id write the tail; pop
// removes the head; full, empty and head report state.
// A push while full is dropped even if a pop happens in the same cycle.
module riscvbc_tag_fifo
    import riscvbc_mem_arb_pkg::*;
#(
    parameter int unsigned p_depth = RiscvbcMemArbDepth
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  port_id_t push_id,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output port_id_t head
);

    localparam int unsigned PtrW = $clog2(p_depth);
    localparam int unsigned CntW = $clog2(p_depth + 1);

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    port_id_t        mem_q [p_depth];

    logic do_push, do_pop;

    assign full    = (count_q == CntW'(p_depth));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are power-of-two sized, so plain increment wraps
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id;
    end

endmodule

// File: rtl/riscvbc_mem_arb.sv
// Two-cache to single-memory arbiter.
// Ports: clk, reset (sync, active-high); cache0/cache1 request val/rdy/msg
// in, cache0/cache1 response val/rdy/msg out; memreq and memresp to the single
// memory port; err is a sticky flag for a response with no outstanding request.
// Requests are granted round-robin and pass combinationally to memory; the
// granted port ID is queued so responses, which return in order, are routed
// back to the right cache combinationally.
module riscvbc_mem_arb
    import riscvbc_mem_arb_pkg::*;
#(
    parameter int unsigned p_req_sz  = VcMemReqMsgSz,
    parameter int unsigned p_resp_sz = VcMemRespMsgSz,
    parameter int unsigned p_depth   = RiscvbcMemArbDepth
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cache0req_val,
    output logic                 cache0req_rdy,
    input  logic [p_req_sz-1:0]  cache0req_msg,
    input  logic                 cache1req_val,
    output logic                 cache1req_rdy,
    input  logic [p_req_sz-1:0]  cache1req_msg,

    output logic                 cache0resp_val,
    input  logic                 cache0resp_rdy,
    output logic [p_resp_sz-1:0] cache0resp_msg,
    output logic                 cache1resp_val,
    input  logic                 cache1resp_rdy,
    output logic [p_resp_sz-1:0] cache1resp_msg,

    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    output logic [p_req_sz-1:0]  memreq_msg,
    input  logic                 memresp_val,
    output logic                 memresp_rdy,
    input  logic [p_resp_sz-1:0] memresp_msg,

    output logic                 err
);

    port_id_t prio_q, prio_d;
    logic     err_q, err_d;
    port_id_t grant, head;
    logic     full, empty;
    logic     req_ok, resp_ok, req_fire, resp_fire;

    // A lone valid port wins; prio only matters when both are valid
    assign grant = (cache0req_val && cache1req_val) ? prio_q : port_id_t'(cache1req_val);

    // Reset gates the request path; the response path is also gated because the
    // queue count only clears at the end of the first reset cycle
    assign req_ok  = ~full & ~reset;
    assign resp_ok = ~empty & ~reset;

    always_comb begin
        memreq_val     = (cache0req_val | cache1req_val) & req_ok;
        memreq_msg     = grant ? cache1req_msg : cache0req_msg;
        cache0req_rdy  = memreq_rdy & req_ok & ~grant;
        cache1req_rdy  = memreq_rdy & req_ok & grant;

        cache0resp_val = memresp_val & resp_ok & ~head;
        cache1resp_val = memresp_val & resp_ok & head;
        cache0resp_msg = memresp_msg;
        cache1resp_msg = memresp_msg;
        memresp_rdy    = resp_ok & (head ? cache1resp_rdy : cache0resp_rdy);

        req_fire       = memreq_val & memreq_rdy;
        resp_fire      = memresp_val & memresp_rdy;

        prio_d         = req_fire ? ~grant : prio_q;
        err_d          = err_q | (memresp_val & empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;

    riscvbc_tag_fifo #(
        .p_depth (p_depth)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (req_fire),
        .push_id (grant),
        .pop     (resp_fire),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

endmodule

// File: tb/tb_riscvbc_mem_arb.sv
// Directed bench for riscvbc_mem_arb. Granted port IDs are pushed to a
// scoreboard queue as requests are driven; responses pop it and check routing.
module tb_riscvbc_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        cache0req_val, cache0req_rdy, cache1req_val, cache1req_rdy;
    logic [66:0] cache0req_msg, cache1req_msg;
    logic        cache0resp_val, cache0resp_rdy, cache1resp_val, cache1resp_rdy;
    logic [34:0] cache0resp_msg, cache1resp_msg;
    logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [66:0] memreq_msg;
    logic [34:0] memresp_msg;
    logic        err;

    int   n_total = 0;
    int   n_bad   = 0;
    logic sb_q[$];
    logic err_m = 1'b0;

    localparam logic [66:0] Msg0 = {1'b0, 32'h0000_0100, 2'b00, 32'h0};
    localparam logic [66:0] Msg1 = {1'b1, 32'h0000_0200, 2'b00, 32'h1234_5678};

    always #5 clk = ~clk;

    riscvbc_mem_arb dut (
        .clk            (clk),
        .reset          (reset),
        .cache0req_val  (cache0req_val),
        .cache0req_rdy  (cache0req_rdy),
        .cache0req_msg  (cache0req_msg),
        .cache1req_val  (cache1req_val),
        .cache1req_rdy  (cache1req_rdy),
        .cache1req_msg  (cache1req_msg),
        .cache0resp_val (cache0resp_val),
        .cache0resp_rdy (cache0resp_rdy),
        .cache0resp_msg (cache0resp_msg),
        .cache1resp_val (cache1resp_val),
        .cache1resp_rdy (cache1resp_rdy),
        .cache1resp_msg (cache1resp_msg),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memreq_msg     (memreq_msg),
        .memresp_val    (memresp_val),
        .memresp_rdy    (memresp_rdy),
        .memresp_msg    (memresp_msg),
        .err            (err)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cache0req_val  = 1'b0;
        cache1req_val  = 1'b0;
        memreq_rdy     = 1'b0;
        memresp_val    = 1'b0;
        cache0resp_rdy = 1'b0;
        cache1resp_rdy = 1'b0;
        memresp_msg    = '0;
    endtask

    // Holds reset for two cycles with every input asserted
    task automatic do_reset();
        reset          = 1'b1;
        cache0req_val  = 1'b1;
        cache1req_val  = 1'b1;
        memreq_rdy     = 1'b1;
        memresp_val    = 1'b1;
        cache0resp_rdy = 1'b1;
        cache1resp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_memreq_val", memreq_val, 1'b0);
        check_eq("rst_c0req_rdy", cache0req_rdy, 1'b0);
        check_eq("rst_c1req_rdy", cache1req_rdy, 1'b0);
        check_eq("rst_c0resp_val", cache0resp_val, 1'b0);
        check_eq("rst_c1resp_val", cache1resp_val, 1'b0);
        check_eq("rst_memresp_rdy", memresp_rdy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        sb_q.delete();
        err_m = 1'b0;
    endtask

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic step(input logic v0, input logic v1, input logic mrdy,
                        input logic rv, input logic rr0, input logic rr1,
                        input logic [31:0] rdata,
                        input logic exp_val, input logic exp_g);
        logic        nonempty, h, exp_mrdy;
        logic [34:0] rmsg;
        rmsg           = {1'b0, 2'b00, rdata};
        cache0req_val  = v0;
        cache1req_val  = v1;
        memreq_rdy     = mrdy;
        memresp_val    = rv;
        memresp_msg    = rmsg;
        cache0resp_rdy = rr0;
        cache1resp_rdy = rr1;
        @(negedge clk);

        check_eq("err", err, err_m);

        nonempty = (sb_q.size() > 0);
        h        = nonempty ? sb_q[0] : 1'b0;
        exp_mrdy = nonempty && (h ? rr1 : rr0);
        check_eq("c0resp_val", cache0resp_val, rv && nonempty && !h);
        check_eq("c1resp_val", cache1resp_val, rv && nonempty && h);
        check_eq("memresp_rdy", memresp_rdy, exp_mrdy);
        if (rv) begin
            check_eq("c0resp_msg", cache0resp_msg, rmsg);
            check_eq("c1resp_msg", cache1resp_msg, rmsg);
            if (exp_mrdy) void'(sb_q.pop_front());
            if (!nonempty) err_m = 1'b1;
        end

        check_eq("memreq_val", memreq_val, exp_val);
        if (exp_val) begin
            check_eq("memreq_msg", memreq_msg, exp_g ? Msg1 : Msg0);
            check_eq("c0req_rdy", cache0req_rdy, mrdy && !exp_g);
            check_eq("c1req_rdy", cache1req_rdy, mrdy && exp_g);
            if (mrdy) sb_q.push_back(exp_g);
        end else if (v0 || v1) begin
            check_eq("c0req_rdy_blk", cache0req_rdy, 1'b0);
            check_eq("c1req_rdy_blk", cache1req_rdy, 1'b0);
        end

        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA000 + i, 1'b0, 1'b0);
    endtask

    initial begin
        cache0req_msg = Msg0;
        cache1req_msg = Msg1;
        idle_inputs();
        do_reset();

        // Lone cache0 read of 0x100, data returns 3 cycles later
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_eq("sb_empty_a", sb_q.size(), 0);

        // Both valid every cycle after reset: grants alternate starting at port 0
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, i[0]);
        drain(4);

        // Stalled memory, 5 back-to-back requests: 5th waits for first pop
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        // Full with a pop this cycle: push still blocked
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hB000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        drain(4);

        // Requests ordered 1,0,1; one response overlaps a new push
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC00A, 1'b1, 1'b0);
        drain(3);
        check_eq("sb_empty_d", sb_q.size(), 0);

        // Head port 0 not ready while port 1 is: response held
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hE000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hE000, 1'b0, 1'b0);
        check_eq("sb_empty_e", sb_q.size(), 0);

        // Orphan response: err sets and sticks until reset
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_step();
        check_eq("err_sticky", err, 1'b1);
        do_reset();
        check_eq("err_cleared", err, 1'b0);
        // prio back to port 0 and count back to 0 (4 fires accepted)
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, i[0]);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drain(4);
        idle_step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
